mcdt_mux: RTL and testbench
===========================

Name: mcdt_mux

Overview:
Three-channel data transfer block. Each channel has a small input FIFO with valid/ready back-pressure and a free-space (margin) report. A single arbiter drains the FIFOs onto one shared output stream, one word per cycle, tagged with the source channel id. It sits between three independent producers and a single downstream consumer that is always ready.

Parameters:
DATA_WIDTH, 32, width of every channel data word and of mcdt_data_o.
FIFO_DEPTH, 32, words per channel FIFO; must be a power of 2 and ≤32. Margin width is fixed at 6 bits.

Ports:
clk  input  1  clock, rising-edge active
rstn  input  1  reset, asynchronous, active-high
ch0_data_i  input  DATA_WIDTH  channel 0 write data
ch0_valid_i  input  1  channel 0 write request
ch0_ready_o  output  1  channel 0 FIFO not full
ch0_margin_o  output  6  channel 0 free slots (FIFO_DEPTH − count)
ch1_data_i / ch1_valid_i / ch1_ready_o / ch1_margin_o  same as channel 0, for channel 1
ch2_data_i / ch2_valid_i / ch2_ready_o / ch2_margin_o  same as channel 0, for channel 2
mcdt_data_o  output  DATA_WIDTH  forwarded word
mcdt_val_o  output  1  mcdt_data_o/mcdt_id_o valid this cycle
mcdt_id_o  output  2  source channel of forwarded word (0,1,2)

Behaviour:
- Reset (rstn high, async): all FIFOs flushed; chN_ready_o=1; chN_margin_o=FIFO_DEPTH (32); mcdt_val_o=0, mcdt_data_o=0, mcdt_id_o=0. Assertion mid-transfer discards all buffered and in-flight words immediately.
- Write: word pushed at a rising edge when chN_valid_i & chN_ready_o. While valid is high and ready is low, nothing is written; the producer must hold data and valid. Valid high on consecutive cycles writes one word per cycle.
- chN_ready_o = !full, combinational from the FIFO count. A pop in the same cycle does not make a full FIFO writable.
- chN_margin_o = FIFO_DEPTH − count, combinational from the registered count. Range 0..32. It updates on the edge that pushes or pops. A simultaneous push and pop leaves it unchanged.
- Arbitration, fixed priority ch0 > ch1 > ch2. Each cycle the arbiter selects the highest-priority non-empty FIFO. At the next rising edge it pops one word and registers it onto the outputs: mcdt_val_o=1, mcdt_data_o=word, mcdt_id_o=channel.
- If all FIFOs are empty, the next edge registers mcdt_val_o=0, mcdt_data_o=0, mcdt_id_o=0.
- Latency: a word written at edge k into an otherwise idle block is popped at edge k+1. It is presented on the outputs for exactly one cycle, from edge k+1 to edge k+2.
- Throughput: one output word per cycle in aggregate. A lower-priority channel waits while a higher one is non-empty; starvation is permitted in fixed-priority mode.
- Per-channel ordering is FIFO order. There is no reordering within a channel.
- Pointer wrap-around uses log2(FIFO_DEPTH)+1-bit pointers; full and empty are distinguished by the MSB.

Optional Feature:
- MCDT_RR_ARB_EN defined: round-robin arbitration. A 2-bit last-grant register (reset 2, so ch0 is first). Search order starts at last_grant+1 mod 3; only non-empty channels are granted; last_grant updates on every grant.
  - Example: all three FIFOs non-empty → ids 0,1,2,0,1,2…
- MCDT_RR_ARB_EN undefined: fixed priority ch0>ch1>ch2 as above.

Test Plan:
- Reset: assert rstn 10 cycles → all margins 32, all readies 1, mcdt_val_o 0, mcdt_data_o 0, mcdt_id_o 0.
- Channel 0 single writes: ten writes 0x00C0_0000..0x00C0_0009, valid pulsed 1 cycle high, 1 cycle low → ten output beats.
  - Each beat: mcdt_val_o=1, mcdt_id_o=0, data in order, 1 edge after its write.
  - ch0_margin_o toggles 32→31→32.
- Channels 1 and 2: same pattern with 0x00C1_000x and 0x00C2_000x → mcdt_id_o=1 then 2 respectively, data in order, no lost or duplicated words.
- Contention: write 0xA0, 0xA1, 0xA2 to ch0..ch2 in the same cycle → next three output cycles carry ids 0,1,2.
  - With MCDT_RR_ARB_EN and continuous traffic on all channels: the grant sequence rotates 0,1,2.
- Full: stream 40 back-to-back words into ch0 while ch1 is kept continuously busy with higher traffic. Force the full case by driving 33 writes while the arbiter serves ch0 one per cycle but ch0 can't win (swap priority via RR off and ch0 writes … see next).
  - Simpler form: hold mcdt output free and write 33 words in consecutive cycles to ch2 while ch0 is refilled every cycle → ch2_margin_o reaches 0, ch2_ready_o=0, the 33rd word is held until ready, and all 33 words eventually emerge in order.
- Reset mid-operation: assert rstn with 5 words buffered in ch1 → outputs zero immediately, ch1_margin_o=32, no stale words after release.

Source files
------------

// File: rtl/mcdt_mux.sv
// mcdt_mux: three-channel FIFO buffered data multiplexer.
//
// Three producers each feed a private FIFO through a valid/ready handshake.
// A single arbiter drains one word per cycle from the FIFOs onto a shared
// registered output stream, tagged with the source channel id.
//
// Ports:
//   clk, rstn                 clock (rising edge), reset (async, active-high)
//   chN_data_i/chN_valid_i    channel N write data / write request
//   chN_ready_o               channel N FIFO not full
//   chN_margin_o              channel N free slots (FIFO_DEPTH - count)
//   mcdt_data_o/_val_o/_id_o  forwarded word, valid strobe, source channel
//
// Build option:
//   MCDT_RR_ARB_EN  defined   -> round-robin arbitration (ch0 first after reset)
//                   undefined -> fixed priority ch0 > ch1 > ch2

module mcdt_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [5:0]            margin,
    input  logic                  rd_en,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [AW:0]           count;
    logic                  full;
    logic                  push;

    // Extra pointer MSB tells full (MSBs differ) from empty (MSBs equal).
    assign count    = wr_ptr_q - rd_ptr_q;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_ready = !full;
    assign margin   = 6'(FIFO_DEPTH) - 6'(count);
    assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    // Full blocks writes even when a pop happens in the same cycle.
    assign push     = wr_valid && !full;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (rd_en && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

module mcdt_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] ch0_data_i,
    input  logic                  ch0_valid_i,
    output logic                  ch0_ready_o,
    output logic [5:0]            ch0_margin_o,
    input  logic [DATA_WIDTH-1:0] ch1_data_i,
    input  logic                  ch1_valid_i,
    output logic                  ch1_ready_o,
    output logic [5:0]            ch1_margin_o,
    input  logic [DATA_WIDTH-1:0] ch2_data_i,
    input  logic                  ch2_valid_i,
    output logic                  ch2_ready_o,
    output logic [5:0]            ch2_margin_o,
    output logic [DATA_WIDTH-1:0] mcdt_data_o,
    output logic                  mcdt_val_o,
    output logic [1:0]            mcdt_id_o
);
    localparam int NUM_CH = 3;

    logic [NUM_CH-1:0][DATA_WIDTH-1:0] wr_data;
    logic [NUM_CH-1:0]                 wr_valid;
    logic [NUM_CH-1:0]                 wr_ready;
    logic [NUM_CH-1:0][5:0]            margin;
    logic [NUM_CH-1:0]                 rd_en;
    logic [NUM_CH-1:0]                 empty;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] rd_data;

    logic                  grant_vld;
    logic [1:0]            grant_id;
    logic                  val_q, val_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            id_q, id_d;

    assign wr_data  = {ch2_data_i, ch1_data_i, ch0_data_i};
    assign wr_valid = {ch2_valid_i, ch1_valid_i, ch0_valid_i};

    assign ch0_ready_o  = wr_ready[0];
    assign ch1_ready_o  = wr_ready[1];
    assign ch2_ready_o  = wr_ready[2];
    assign ch0_margin_o = margin[0];
    assign ch1_margin_o = margin[1];
    assign ch2_margin_o = margin[2];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign rd_en[g] = grant_vld && (grant_id == 2'(g));

        mcdt_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rstn     (rstn),
            .wr_data  (wr_data[g]),
            .wr_valid (wr_valid[g]),
            .wr_ready (wr_ready[g]),
            .margin   (margin[g]),
            .rd_en    (rd_en[g]),
            .empty    (empty[g]),
            .rd_data  (rd_data[g])
        );
    end

`ifdef MCDT_RR_ARB_EN
    logic [1:0] last_grant_q, last_grant_d;
    logic [1:0] cand;

    // Search starts one past the last granted channel, wrapping modulo 3.
    always_comb begin
        grant_vld    = 1'b0;
        grant_id     = 2'd0;
        cand         = 2'd0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = 2'((int'(last_grant_q) + k) % NUM_CH);
            if (!grant_vld && !empty[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
        last_grant_d = grant_vld ? grant_id : last_grant_q;
    end

    // Reset value 2 makes channel 0 the first candidate.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) last_grant_q <= 2'd2;
        else      last_grant_q <= last_grant_d;
    end
`else
    always_comb begin
        grant_vld = 1'b1;
        grant_id  = 2'd0;
        if      (!empty[0]) grant_id = 2'd0;
        else if (!empty[1]) grant_id = 2'd1;
        else if (!empty[2]) grant_id = 2'd2;
        else                grant_vld = 1'b0;
    end
`endif

    // Idle cycles drive the whole output bus to zero, not just the strobe.
    always_comb begin
        val_d  = grant_vld;
        data_d = grant_vld ? rd_data[grant_id] : '0;
        id_d   = grant_vld ? grant_id : 2'd0;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            val_q  <= 1'b0;
            data_q <= '0;
            id_q   <= 2'd0;
        end else begin
            val_q  <= val_d;
            data_q <= data_d;
            id_q   <= id_d;
        end
    end

    assign mcdt_val_o  = val_q;
    assign mcdt_data_o = data_q;
    assign mcdt_id_o   = id_q;
endmodule

// File: tb/tb_mcdt_mux.sv
module tb_mcdt_mux;
    logic            clk = 1'b0;
    logic            rstn = 1'b1;
    logic [2:0][31:0] din;
    logic [2:0]      vin;
    logic [2:0]      rdy;
    logic [2:0][5:0] mrg;
    logic [31:0]     mcdt_data_o;
    logic            mcdt_val_o;
    logic [1:0]      mcdt_id_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mcdt_mux #(.DATA_WIDTH(32), .FIFO_DEPTH(32)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .ch0_data_i   (din[0]),
        .ch0_valid_i  (vin[0]),
        .ch0_ready_o  (rdy[0]),
        .ch0_margin_o (mrg[0]),
        .ch1_data_i   (din[1]),
        .ch1_valid_i  (vin[1]),
        .ch1_ready_o  (rdy[1]),
        .ch1_margin_o (mrg[1]),
        .ch2_data_i   (din[2]),
        .ch2_valid_i  (vin[2]),
        .ch2_ready_o  (rdy[2]),
        .ch2_margin_o (mrg[2]),
        .mcdt_data_o  (mcdt_data_o),
        .mcdt_val_o   (mcdt_val_o),
        .mcdt_id_o    (mcdt_id_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per-channel queues, one pop per edge chosen by the
    // arbitration rule on the contents before the edge, then pushes.
    logic [31:0] q [3][$];
    logic        e_val  = 1'b0;
    logic [31:0] e_data = '0;
    logic [1:0]  e_id   = '0;
    int          lg     = 2;

    always @(posedge clk or posedge rstn) begin
        int g;
        bit acc [3];
        if (rstn) begin
            for (int c = 0; c < 3; c++) q[c].delete();
            e_val = 0; e_data = 0; e_id = 0; lg = 2;
        end else begin
            g = -1;
`ifdef MCDT_RR_ARB_EN
            for (int k = 1; k <= 3; k++)
                if (g < 0 && q[(lg + k) % 3].size() > 0) g = (lg + k) % 3;
`else
            for (int c = 0; c < 3; c++)
                if (g < 0 && q[c].size() > 0) g = c;
`endif
            for (int c = 0; c < 3; c++) acc[c] = vin[c] && (q[c].size() < 32);
            if (g >= 0) begin
                e_val = 1; e_data = q[g].pop_front(); e_id = 2'(g); lg = g;
            end else begin
                e_val = 0; e_data = 0; e_id = 0;
            end
            for (int c = 0; c < 3; c++) if (acc[c]) q[c].push_back(din[c]);
        end
    end

    always @(negedge clk) begin
        chk("out_val", 32'(mcdt_val_o), 32'(e_val));
        chk("out_data", mcdt_data_o, e_data);
        chk("out_id", 32'(mcdt_id_o), 32'(e_id));
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("margin%0d", c), 32'(mrg[c]), 32'(32 - q[c].size()));
            chk($sformatf("ready%0d", c), 32'(rdy[c]), 32'(q[c].size() < 32));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        vin = '0;
        @(negedge clk);
        #2 rstn = 1'b1;
        repeat (3) tick();
        rstn = 1'b0;
        tick();
    endtask

    task automatic single_ch(input int c, input logic [31:0] base);
        for (int i = 0; i < 10; i++) begin
            din[c] = base + 32'(i);
            vin[c] = 1'b1;
            tick();
            chk("single_margin_dec", 32'(mrg[c]), 32'd31);
            vin[c] = 1'b0;
            tick();
            chk("single_val", 32'(mcdt_val_o), 32'd1);
            chk("single_id", 32'(mcdt_id_o), 32'(c));
            chk("single_data", mcdt_data_o, base + 32'(i));
            chk("single_margin_back", 32'(mrg[c]), 32'd32);
        end
    endtask

    initial begin
        int n, waited, hold, dens;
        bit acc, saw_full;
        bit pend [3];

        din = '0;
        vin = '0;
        repeat (10) tick();
        rstn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("rst_margin", 32'(mrg[c]), 32'd32);
            chk("rst_ready", 32'(rdy[c]), 32'd1);
        end
        chk("rst_val", 32'(mcdt_val_o), 32'd0);
        chk("rst_data", mcdt_data_o, 32'd0);
        chk("rst_id", 32'(mcdt_id_o), 32'd0);
        tick();

        single_ch(0, 32'h00C0_0000);
        single_ch(1, 32'h00C1_0000);
        single_ch(2, 32'h00C2_0000);

        // Simultaneous writes on all three channels.
        do_reset();
        din[0] = 32'hA0; din[1] = 32'hA1; din[2] = 32'hA2;
        vin = 3'b111;
        tick();
        vin = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("cont_id", 32'(mcdt_id_o), 32'(i));
            chk("cont_data", mcdt_data_o, 32'hA0 + 32'(i));
        end
        tick();

        // Continuous traffic on all channels.
        do_reset();
        vin = 3'b111;
        for (int i = 0; i < 30; i++) begin
            for (int c = 0; c < 3; c++) din[c] = 32'h00B0_0000 + 32'(c * 256 + i);
            tick();
        end
        vin = '0;
        repeat (100) tick();

        // Fill ch2 while ch0 keeps the arbiter busy.
        do_reset();
        n = 0; waited = 0; hold = 0; saw_full = 0;
        while (n < 33 && waited < 300) begin
            vin[0] = (waited < 60) && (!saw_full || hold < 4);
            din[0] = 32'h00F0_0000 + 32'(waited);
            din[2] = 32'h00C2_F000 + 32'(n);
            vin[2] = 1'b1;
            acc = rdy[2];
            tick();
            waited++;
            if (acc) n++;
            if (saw_full) hold++;
            if (!rdy[2] && !saw_full) begin
                saw_full = 1;
                chk("full_margin", 32'(mrg[2]), 32'd0);
                chk("full_count", 32'(n), 32'd32);
            end
        end
        chk("full_all_written", 32'(n), 32'd33);
`ifndef MCDT_RR_ARB_EN
        chk("full_seen", 32'(saw_full), 32'd1);
`endif
        vin = '0;
        repeat (50) tick();

        // Reset with words still buffered in ch1.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            vin[0] = 1'b1; din[0] = 32'h00D0_0000 + 32'(i);
            vin[1] = (i < 5); din[1] = 32'h00D1_0000 + 32'(i);
            tick();
        end
        #2 rstn = 1'b1;
        vin = '0;
        #1;
        chk("midrst_val", 32'(mcdt_val_o), 32'd0);
        chk("midrst_data", mcdt_data_o, 32'd0);
        chk("midrst_id", 32'(mcdt_id_o), 32'd0);
        chk("midrst_margin1", 32'(mrg[1]), 32'd32);
        repeat (3) tick();
        rstn = 1'b0;
        repeat (8) tick();

        // Randomized traffic at several densities, holding unaccepted words.
        do_reset();
        for (int c = 0; c < 3; c++) pend[c] = 0;
        for (int p = 0; p < 3; p++) begin
            dens = 30 + 30 * p;
            for (int i = 0; i < 600; i++) begin
                for (int c = 0; c < 3; c++) begin
                    if (!pend[c]) begin
                        vin[c] = ($urandom_range(0, 99) < dens);
                        din[c] = $urandom;
                    end
                    pend[c] = vin[c] && !rdy[c];
                end
                tick();
            end
        end
        vin = '0;
        repeat (120) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
